// File: rtl/shell_reset_sequencer.sv
// -----------------------------------------------------------------------------
// shell_reset_sequencer
//
// Brings up the PCIe shell region. It holds the PCIe core in reset
// (pcie_perstn low), waits for link-up together with clock lock, holds the
// user/role logic in reset for a fixed time, and then reports shell_ready.
// The sequence restarts on link loss or on a host soft-reset request.
// Link training is retried with a bounded timeout. Once the retries are
// exhausted the FSM parks in FAIL until a soft reset arrives.
//
// Optional feature macro: SHELL_RST_SYNC_EN
//   defined   : link_up and mmcm_locked each pass through a 2-flop synchroniser
//               (reset to 0) before use.
//   undefined : both inputs are used directly (same-clock source).
//
// Ports
//   clk           in   shell clock
//   reset         in   asynchronous, active-high reset
//   sw_reset_req  in   single-cycle soft-reset request from host MMIO
//   link_up       in   PCIe core link-up status
//   mmcm_locked   in   shell clock generator lock
//   pcie_perstn   out  PCIe core reset, active-low
//   user_reset    out  user/role logic reset, active-high
//   shell_ready   out  shell operational
//   link_timeout  out  sticky flag: at least one link timeout since last clear
//   retry_count   out  [3:0] link timeouts in the current sequence
//   state         out  [2:0] 0 PERST, 1 WAIT_LINK, 2 USER_RST, 3 RUN, 4 FAIL
// -----------------------------------------------------------------------------
module shell_reset_sequencer #(
  parameter int PERST_CYCLES    = 10,
  parameter int LINK_TIMEOUT    = 65535,
  parameter int USER_RST_CYCLES = 16,
  parameter int MAX_RETRY       = 3,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_reset_req,
  input  logic       link_up,
  input  logic       mmcm_locked,
  output logic       pcie_perstn,
  output logic       user_reset,
  output logic       shell_ready,
  output logic       link_timeout,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_PERST     = 3'd0,
    S_WAIT_LINK = 3'd1,
    S_USER_RST  = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PERST_LAST = CNT_W'(PERST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LINK_LAST  = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] USER_LAST  = CNT_W'(USER_RST_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRY);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_retry;
  logic             r_timeout;
  logic             r_perstn;
  logic             r_user_reset;
  logic             r_shell_ready;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_cnt_next;
  logic [3:0]       w_retry_next;
  logic [3:0]       w_retry_inc;
  logic             w_timeout_next;
  logic             w_link_ok;

`ifdef SHELL_RST_SYNC_EN
  logic [1:0] r_link_sync;
  logic [1:0] r_lock_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_link_sync <= 2'b00;
      r_lock_sync <= 2'b00;
    end else begin
      r_link_sync <= {r_link_sync[0], link_up};
      r_lock_sync <= {r_lock_sync[0], mmcm_locked};
    end
  end

  assign w_link_ok = r_link_sync[1] & r_lock_sync[1];
`else
  assign w_link_ok = link_up & mmcm_locked;
`endif

  // Saturating increment. FAIL is entered on reaching the maximum, so the
  // saturation branch is a safety net that keeps the count from wrapping.
  assign w_retry_inc = (r_retry == RETRY_MAX) ? r_retry : r_retry + 4'd1;

  always_comb begin
    w_next_state   = r_state;
    w_retry_next   = r_retry;
    w_timeout_next = r_timeout;

    // A soft reset overrides everything except an ongoing PERST phase,
    // where it would only restart a phase that is already running.
    if (sw_reset_req && (r_state != S_PERST)) begin
      w_next_state   = S_PERST;
      w_retry_next   = 4'd0;
      w_timeout_next = 1'b0;
    end else begin
      case (r_state)
        S_PERST: begin
          if (r_cnt == PERST_LAST) w_next_state = S_WAIT_LINK;
        end
        S_WAIT_LINK: begin
          // link_ok takes precedence over a timeout in the same cycle.
          if (w_link_ok) begin
            w_next_state = S_USER_RST;
          end else if (r_cnt == LINK_LAST) begin
            w_timeout_next = 1'b1;
            w_retry_next   = w_retry_inc;
            w_next_state   = (w_retry_inc == RETRY_MAX) ? S_FAIL : S_PERST;
          end
        end
        S_USER_RST: begin
          if (!w_link_ok)              w_next_state = S_WAIT_LINK;
          else if (r_cnt == USER_LAST) w_next_state = S_RUN;
        end
        S_RUN: begin
          if (!w_link_ok) w_next_state = S_WAIT_LINK;
        end
        S_FAIL: begin
          w_next_state = S_FAIL;
        end
        default: begin
          w_next_state = S_PERST;
        end
      endcase
    end

    // A successful bring-up starts a fresh retry budget.
    if ((w_next_state == S_RUN) && (r_state != S_RUN)) w_retry_next = 4'd0;
  end

  // The phase counter clears on every state change and only runs in the
  // timed phases, so it never passes the limit of its phase.
  always_comb begin
    if (w_next_state != r_state)                      w_cnt_next = '0;
    else if ((r_state == S_RUN) || (r_state == S_FAIL)) w_cnt_next = '0;
    else                                              w_cnt_next = r_cnt + CNT_W'(1);
  end

  // Moore outputs are decoded from the next state so the registered values
  // line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_PERST;
      r_cnt         <= '0;
      r_retry       <= 4'd0;
      r_timeout     <= 1'b0;
      r_perstn      <= 1'b0;
      r_user_reset  <= 1'b1;
      r_shell_ready <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_cnt_next;
      r_retry       <= w_retry_next;
      r_timeout     <= w_timeout_next;
      r_perstn      <= !((w_next_state == S_PERST) || (w_next_state == S_FAIL));
      r_user_reset  <= (w_next_state != S_RUN);
      r_shell_ready <= (w_next_state == S_RUN);
    end
  end

  assign pcie_perstn  = r_perstn;
  assign user_reset   = r_user_reset;
  assign shell_ready  = r_shell_ready;
  assign link_timeout = r_timeout;
  assign retry_count  = r_retry;
  assign state        = r_state;

endmodule

// File: tb/tb_shell_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shell_reset_sequencer
//
// Test phases:
//   1. A table of {inputs, hold cycles, expected outputs} records that walks
//      the bring-up, link-loss, timeout/retry, FAIL and soft-reset paths.
//   2. A hand-written sequence that applies an asynchronous reset while the
//      clock is stopped in USER_RST.
//   3. Randomised traffic compared every cycle against a phase/elapsed-time
//      reference model.
// -----------------------------------------------------------------------------
module tb_shell_reset_sequencer;

  localparam int P_PERST = 10;
  localparam int P_LTO   = 100;
  localparam int P_URC   = 16;
  localparam int P_MAXR  = 3;

  logic       clk;
  logic       clk_en;
  logic       reset;
  logic       sw_reset_req;
  logic       link_up;
  logic       mmcm_locked;
  logic       pcie_perstn;
  logic       user_reset;
  logic       shell_ready;
  logic       link_timeout;
  logic [3:0] retry_count;
  logic [2:0] state;

  int n_checks;
  int n_errors;

  shell_reset_sequencer #(
    .PERST_CYCLES   (P_PERST),
    .LINK_TIMEOUT   (P_LTO),
    .USER_RST_CYCLES(P_URC),
    .MAX_RETRY      (P_MAXR),
    .CNT_W          (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_reset_req(sw_reset_req),
    .link_up     (link_up),
    .mmcm_locked (mmcm_locked),
    .pcie_perstn (pcie_perstn),
    .user_reset  (user_reset),
    .shell_ready (shell_ready),
    .link_timeout(link_timeout),
    .retry_count (retry_count),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  // ---------------- reference model ----------------
  // The model tracks which phase the sequencer is in and how many whole
  // cycles it has spent there. Phases: 0 PERST,1 WAIT_LINK,2 USER_RST,3 RUN,4 FAIL.
  int m_phase;
  int m_elapsed;
  int m_retry;
  int m_to;

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_retry = 0; m_to = 0;
  endtask

  task automatic model_step(input bit sw, input bit ok);
    int nxt;
    nxt = m_phase;
    if (sw && m_phase != 0) begin
      nxt = 0; m_retry = 0; m_to = 0;
    end else if (m_phase == 0) begin
      if (m_elapsed + 1 == P_PERST) nxt = 1;
    end else if (m_phase == 1) begin
      if (ok) nxt = 2;
      else if (m_elapsed + 1 == P_LTO) begin
        m_to = 1;
        m_retry = (m_retry + 1 > P_MAXR) ? P_MAXR : m_retry + 1;
        nxt = (m_retry == P_MAXR) ? 4 : 0;
      end
    end else if (m_phase == 2) begin
      if (!ok) nxt = 1;
      else if (m_elapsed + 1 == P_URC) nxt = 3;
    end else if (m_phase == 3) begin
      if (!ok) nxt = 1;
    end
    if (nxt == 3 && m_phase != 3) m_retry = 0;
    m_elapsed = (nxt != m_phase) ? 0 : m_elapsed + 1;
    m_phase = nxt;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int pn, input int ur,
                           input int rdy, input int to, input int rc);
    chk({tag, ".state"},        int'(state),        st);
    chk({tag, ".pcie_perstn"},  int'(pcie_perstn),  pn);
    chk({tag, ".user_reset"},   int'(user_reset),   ur);
    chk({tag, ".shell_ready"},  int'(shell_ready),  rdy);
    chk({tag, ".link_timeout"}, int'(link_timeout), to);
    chk({tag, ".retry_count"},  int'(retry_count),  rc);
  endtask

  task automatic check_model(input string tag);
    check_all(tag, m_phase,
              (m_phase != 0 && m_phase != 4) ? 1 : 0,
              (m_phase != 3) ? 1 : 0,
              (m_phase == 3) ? 1 : 0,
              m_to, m_retry);
  endtask

  // One clock edge; the model consumes the inputs that were stable at the edge.
  task automatic tick();
    @(posedge clk);
    model_step(sw_reset_req, link_up & mmcm_locked);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic sw;
    logic lnk;
    logic lck;
    int   hold;
    int   st;
    int   pn;
    int   rdy;
    int   rc;
    int   to;
  } vec_t;

  vec_t vq[$];

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk_en = 1'b1;
    reset = 1'b1;
    sw_reset_req = 1'b0;
    link_up = 1'b1;
    mmcm_locked = 1'b1;
    model_reset();

    //            sw    lnk   lck   hold  st pn rdy rc to
    vq.push_back('{1'b0, 1'b1, 1'b1, 10,  1, 1, 0, 0, 0}); // perstn high after edge 10
    vq.push_back('{1'b0, 1'b1, 1'b1, 1,   2, 1, 0, 0, 0}); // USER_RST after edge 11
    vq.push_back('{1'b0, 1'b1, 1'b1, 15,  2, 1, 0, 0, 0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1,   3, 1, 1, 0, 0}); // RUN after edge 27
    vq.push_back('{1'b0, 1'b0, 1'b1, 1,   1, 1, 0, 0, 0}); // link loss in RUN
    vq.push_back('{1'b0, 1'b1, 1'b1, 16,  2, 1, 0, 0, 0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1,   3, 1, 1, 0, 0}); // back in RUN after 17 edges
    vq.push_back('{1'b0, 1'b1, 1'b0, 1,   1, 1, 0, 0, 0}); // lock loss in RUN
    vq.push_back('{1'b0, 1'b1, 1'b1, 17,  3, 1, 1, 0, 0});
    vq.push_back('{1'b1, 1'b0, 1'b1, 1,   0, 0, 0, 0, 0}); // soft reset beats link loss
    vq.push_back('{1'b1, 1'b0, 1'b1, 1,   0, 0, 0, 0, 0}); // ignored in PERST
    vq.push_back('{1'b0, 1'b0, 1'b1, 8,   0, 0, 0, 0, 0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 1,   1, 1, 0, 0, 0}); // PERST length unchanged
    vq.push_back('{1'b0, 1'b0, 1'b1, 99,  1, 1, 0, 0, 0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 1,   0, 0, 0, 1, 1}); // first timeout
    vq.push_back('{1'b0, 1'b0, 1'b1, 110, 0, 0, 0, 2, 1}); // second timeout
    vq.push_back('{1'b0, 1'b0, 1'b1, 110, 4, 0, 0, 3, 1}); // third -> parked
    vq.push_back('{1'b0, 1'b1, 1'b1, 20,  4, 0, 0, 3, 1}); // link alone does not exit
    vq.push_back('{1'b1, 1'b1, 1'b1, 1,   0, 0, 0, 0, 0}); // soft reset exits and clears
    vq.push_back('{1'b0, 1'b1, 1'b1, 27,  3, 1, 1, 0, 0}); // ready 27 edges later
    vq.push_back('{1'b0, 1'b0, 1'b1, 1,   1, 1, 0, 0, 0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 99,  1, 1, 0, 0, 0});
    vq.push_back('{1'b0, 1'b1, 1'b1, 1,   2, 1, 0, 0, 0}); // link_ok wins at timeout cycle
    vq.push_back('{1'b0, 1'b1, 1'b1, 16,  3, 1, 1, 0, 0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 1,   1, 1, 0, 0, 0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 100, 0, 0, 0, 1, 1});
    vq.push_back('{1'b0, 1'b1, 1'b1, 27,  3, 1, 1, 0, 1}); // retry cleared, flag sticky
    vq.push_back('{1'b1, 1'b1, 1'b1, 1,   0, 0, 0, 0, 0}); // soft reset clears flag
    vq.push_back('{1'b0, 1'b1, 1'b1, 11,  2, 1, 0, 0, 0});
    vq.push_back('{1'b1, 1'b1, 1'b1, 1,   0, 0, 0, 0, 0}); // soft reset from USER_RST

    #23;
    check_all("reset", 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[i]) begin
      sw_reset_req = vq[i].sw;
      link_up      = vq[i].lnk;
      mmcm_locked  = vq[i].lck;
      for (int c = 0; c < vq[i].hold; c++) begin
        tick();
        sw_reset_req = 1'b0;   // soft reset is a single-cycle pulse
      end
      check_all($sformatf("vec%0d", i), vq[i].st, vq[i].pn, 1 - vq[i].rdy,
                vq[i].rdy, vq[i].to, vq[i].rc);
      $display("vec %0d: sw=%0d link=%0d lock=%0d hold=%0d -> state=%0d perstn=%0d ready=%0d retry=%0d to=%0d",
               i, vq[i].sw, vq[i].lnk, vq[i].lck, vq[i].hold, state, pcie_perstn,
               shell_ready, retry_count, link_timeout);
    end

    // ---------------- async reset with the clock stopped ----------------
    link_up = 1'b0;
    repeat (P_PERST + P_LTO) tick();
    link_up = 1'b1;
    repeat (P_PERST + 1 + 5) tick();
    check_all("pre_async", 2, 1, 1, 0, 1, 1);
    clk_en = 1'b0;          // clk stays high: no further edges
    #3;
    reset = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 1, 0, 0, 0);
    $display("async reset with stopped clock: state=%0d perstn=%0d user_reset=%0d retry=%0d",
             state, pcie_perstn, user_reset, retry_count);
    #20;
    reset = 1'b0;
    model_reset();
    #2;
    clk_en = 1'b1;

    // ---------------- randomised traffic vs reference model ----------------
    for (int b = 0; b < 15; b++) begin
      bit mode;
      int err_before;
      mode = 1'($urandom_range(0, 1));
      err_before = n_errors;
      for (int c = 0; c < 200; c++) begin
        link_up      = mode ? ($urandom_range(0, 99) != 0) : ($urandom_range(0, 99) < 2);
        mmcm_locked  = ($urandom_range(0, 199) != 0);
        sw_reset_req = ($urandom_range(0, 299) == 0);
        tick();
        check_model($sformatf("rnd%0d.%0d", b, c));
      end
      $display("burst %0d: mode=%0d end state=%0d retry=%0d to=%0d new_errors=%0d",
               b, mode, state, retry_count, link_timeout, n_errors - err_before);
    end
    sw_reset_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
